// File: rtl/axa_pkg.sv
// AXA shared definitions: opcodes, instruction field ranges, type codes and
// opcode classification used by the fetch and execute stages.
package axa_pkg;

   localparam int IOPLEN = 6;
   localparam int IFORM  = 15;

   // long form: op[15:10] typ[9:8] dst[7:4] src[3:0]
   localparam int IL_OP_HI  = 15;
   localparam int IL_OP_LO  = 10;
   localparam int IL_TYP_HI = 9;
   localparam int IL_TYP_LO = 8;
   localparam int IL_DST_HI = 7;
   localparam int IL_DST_LO = 4;
   localparam int IL_SRC_HI = 3;
   localparam int IL_SRC_LO = 0;

   // short form: op[15:12] srch[11:8] dst[7:4] srcl[3:0]
   localparam int IS_OP_HI   = 15;
   localparam int IS_OP_LO   = 12;
   localparam int IS_SRCH_HI = 11;
   localparam int IS_SRCH_LO = 8;
   localparam int IS_DST_HI  = 7;
   localparam int IS_DST_LO  = 4;
   localparam int IS_SRCL_HI = 3;
   localparam int IS_SRCL_LO = 0;

   localparam logic [1:0] ILTypeImm = 2'b00;
   localparam logic [1:0] ILTypeReg = 2'b01;
   localparam logic [1:0] ILTypeMem = 2'b10;
   localparam logic [1:0] ILTypeUnd = 2'b11;

   localparam logic [2:0]        OPG_BRANCH = 3'b101;
   localparam logic [IOPLEN-1:0] OPjerr = 6'b110000;
   localparam logic [IOPLEN-1:0] OPfail = 6'b110001;
   localparam logic [IOPLEN-1:0] OPex   = 6'b110010;
   localparam logic [IOPLEN-1:0] OPland = 6'b110100;
   localparam logic [IOPLEN-1:0] OPsys  = 6'b111000;
   localparam logic [IOPLEN-1:0] OPnop  = 6'b111010;

   localparam logic [15:0] NOP_IR = {OPnop, 10'b0};

   typedef enum logic [1:0] {ST_RUN, ST_CTRL_WAIT, ST_HOLD} fetch_state_t;

   function automatic logic isBranch(input logic [IOPLEN-1:0] op);
      return op[IOPLEN-1 -: 3] == OPG_BRANCH;
   endfunction

   // ops whose successor is only known once a later stage resolves them
   function automatic logic isCtrl(input logic [IOPLEN-1:0] op);
      return isBranch(op) || op == OPjerr || op == OPland;
   endfunction

   function automatic logic isBlocking(input logic [IOPLEN-1:0] op);
      return op == OPsys || op == OPfail || op == OPex;
   endfunction

endpackage

// File: rtl/axa_decode.sv
// Combinational AXA instruction decoder: ir -> {op, typ, dst, src}.
module axa_decode import axa_pkg::*; (
   input  logic [15:0]       ir,
   output logic [IOPLEN-1:0] op,
   output logic [1:0]        typ,
   output logic [3:0]        dst,
   output logic [15:0]       src
);

   always_comb begin
      dst = ir[IL_DST_HI:IL_DST_LO];
      if (!ir[IFORM]) begin
         op  = {ir[IS_OP_HI:IS_OP_LO], 2'b00};
         typ = ILTypeImm;
         src = {{8{ir[IS_SRCH_HI]}}, ir[IS_SRCH_HI:IS_SRCH_LO], ir[IS_SRCL_HI:IS_SRCL_LO]};
      end else begin
         op  = ir[IL_OP_HI:IL_OP_LO];
         typ = ir[IL_TYP_HI:IL_TYP_LO];
         // only immediates are signed; register/memory selectors are plain indices
         if (ir[IL_TYP_HI:IL_TYP_LO] == ILTypeImm)
            src = {{12{ir[IL_SRC_HI]}}, ir[IL_SRC_HI:IL_SRC_LO]};
         else
            src = {12'h000, ir[IL_SRC_HI:IL_SRC_LO]};
      end
   end

endmodule

// File: rtl/axa_fetch.sv
// AXA front end: bidirectional PC, instruction memory, fetch and decode,
// self-blocking behind control-flow and blocking ops.
module axa_fetch import axa_pkg::*; #(
   parameter int          AW       = 16,
   parameter logic [15:0] NOP_WORD = NOP_IR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              rev,
   input  logic              redir_valid,
   input  logic [AW-1:0]     redir_pc,
   input  logic              ctrl_done,
   input  logic              release_op,
   input  logic              im_we,
   input  logic [AW-1:0]     im_waddr,
   input  logic [15:0]       im_wdata,
   output logic [15:0]       out_ir,
   output logic              out_valid,
   output logic [AW-1:0]     out_pc,
   output logic [AW-1:0]     out_lastpc,
   output logic [IOPLEN-1:0] out_op,
   output logic [1:0]        out_typ,
   output logic [3:0]        out_dst,
   output logic [15:0]       out_src
);

   localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [15:0]       im [0:(2**AW)-1];
   fetch_state_t      state, state_d;
   logic [AW-1:0]     pc, pc_step;
   logic [15:0]       rd_ir;
   logic [IOPLEN-1:0] rd_op;
   logic              hold_ctrl, hold_blk;
   logic              fetch, advance;

   always_ff @(posedge clk)
      if (im_we) im[im_waddr] <= im_wdata;

   // short-form words have bit 15 clear, so they never classify as ctrl/blocking
   assign rd_ir     = im[pc];
   assign rd_op     = rd_ir[IL_OP_HI:IL_OP_LO];
   assign hold_ctrl = isCtrl(rd_op);
   assign hold_blk  = isBlocking(rd_op);
   assign pc_step   = rev ? pc - PC_ONE : pc + PC_ONE;

   always_ff @(posedge clk)
      if (reset) state <= ST_RUN;
      else       state <= state_d;

   always_comb begin
      state_d = state;
      if (redir_valid)
         state_d = ST_RUN;
      else if (!stall)
         case (state)
            ST_RUN:
               if (hold_ctrl)     state_d = ST_CTRL_WAIT;
               else if (hold_blk) state_d = ST_HOLD;
            ST_CTRL_WAIT: if (ctrl_done)  state_d = ST_RUN;
            ST_HOLD:      if (release_op) state_d = ST_RUN;
            default:                      state_d = ST_RUN;
         endcase
   end

   always_comb begin
      fetch   = 1'b0;
      advance = 1'b0;
      if (!redir_valid && !stall)
         case (state)
            ST_RUN: begin
               fetch   = 1'b1;
               advance = !(hold_ctrl || hold_blk);
            end
            ST_CTRL_WAIT: advance = ctrl_done;
            ST_HOLD:      advance = release_op;
            default: ;
         endcase
   end

   // out_lastpc trails out_pc by one issue, so after a redirect it still
   // names the instruction that was in flight when the redirect arrived
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= '0;
         out_lastpc <= '0;
         out_ir     <= NOP_WORD;
         out_valid  <= 1'b0;
         out_pc     <= '0;
      end else if (redir_valid) begin
         out_lastpc <= out_pc;
         pc         <= redir_pc;
         out_ir     <= NOP_WORD;
         out_valid  <= 1'b0;
      end else if (!stall) begin
         if (advance) pc <= pc_step;
         if (fetch) begin
            out_ir     <= rd_ir;
            out_valid  <= 1'b1;
            out_pc     <= pc;
            out_lastpc <= out_pc;
         end else begin
            out_ir    <= NOP_WORD;
            out_valid <= 1'b0;
         end
      end
   end

   axa_decode u_dec (
      .ir  (out_ir),
      .op  (out_op),
      .typ (out_typ),
      .dst (out_dst),
      .src (out_src)
   );

endmodule

// File: tb/tb_axa_fetch.sv
// Scoreboard bench for axa_fetch: expected fetches are queued as stimulus is
// driven and retired by a monitor whenever a fresh valid fetch appears.
module tb_axa_fetch;

   localparam logic [15:0] NOP = 16'hE800;

   logic        clk = 1'b0;
   logic        reset, stall, rev, redir_valid, ctrl_done, release_op, im_we;
   logic [15:0] redir_pc, im_waddr, im_wdata;
   logic [15:0] out_ir, out_pc, out_lastpc, out_src;
   logic        out_valid;
   logic [5:0]  out_op;
   logic [1:0]  out_typ;
   logic [3:0]  out_dst;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] ir;
      logic [5:0]  op;
      logic [1:0]  typ;
      logic [3:0]  dst;
      logic [15:0] src;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic fresh = 1'b0;

   axa_fetch #(.AW(16), .NOP_WORD(16'hE800)) dut (
      .clk(clk), .reset(reset), .stall(stall), .rev(rev),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .ctrl_done(ctrl_done), .release_op(release_op),
      .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
      .out_ir(out_ir), .out_valid(out_valid), .out_pc(out_pc),
      .out_lastpc(out_lastpc), .out_op(out_op), .out_typ(out_typ),
      .out_dst(out_dst), .out_src(out_src)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [15:0] pc, input logic [15:0] ir);
      exp_t e;
      e.pc  = pc;
      e.ir  = ir;
      e.dst = ir[7:4];
      if (!ir[15]) begin
         e.op  = {ir[15:12], 2'b00};
         e.typ = 2'b00;
         e.src = {{8{ir[11]}}, ir[11:8], ir[3:0]};
      end else begin
         e.op  = ir[15:10];
         e.typ = ir[9:8];
         e.src = (ir[9:8] == 2'b00) ? {{12{ir[3]}}, ir[3:0]} : {12'h000, ir[3:0]};
      end
      return e;
   endfunction

   task automatic push(input logic [15:0] pc, input logic [15:0] ir);
      sb.push_back(mk(pc, ir));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; rev = 1'b0; redir_valid = 1'b0; redir_pc = '0;
      ctrl_done = 1'b0; release_op = 1'b0; im_we = 1'b0; im_waddr = '0; im_wdata = '0;
      tick();
      tick();
      sb.delete();
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] d);
      im_we = 1'b1; im_waddr = a; im_wdata = d;
      tick();
      im_we = 1'b0;
   endtask

   // a valid output counts as a new fetch only if the edge that produced it
   // was not blocked by reset, stall or redirect
   always @(posedge clk) fresh <= !reset && !stall && !redir_valid;

   always @(negedge clk) begin
      if (fresh && out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got fetch pc=%h ir=%h, want no fetch", out_pc, out_ir);
         end else begin
            mon_e = sb.pop_front();
            if (out_pc !== mon_e.pc || out_ir !== mon_e.ir || out_op !== mon_e.op ||
                out_typ !== mon_e.typ || out_dst !== mon_e.dst || out_src !== mon_e.src) begin
               errors++;
               $display("FAIL sb_fetch: got pc=%h ir=%h op=%b typ=%b dst=%h src=%h, want pc=%h ir=%h op=%b typ=%b dst=%h src=%h",
                        out_pc, out_ir, out_op, out_typ, out_dst, out_src,
                        mon_e.pc, mon_e.ir, mon_e.op, mon_e.typ, mon_e.dst, mon_e.src);
            end
         end
      end
   end

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_ir !== NOP) begin errors++; $display("FAIL reset_ir: got %h want %h", out_ir, NOP); end
      checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", out_pc); end
      checks++; if (out_lastpc !== 16'h0000) begin errors++; $display("FAIL reset_lastpc: got %h want 0000", out_lastpc); end
      checks++; if (out_op !== 6'b111010 || out_src !== 16'h0000) begin errors++; $display("FAIL reset_nop_decode: got op=%b src=%h want 111010/0000", out_op, out_src); end
   endtask

   task automatic test_decode();
      do_reset();
      load(16'h0000, 16'h1234);
      load(16'h0001, 16'h80F8);
      load(16'h0002, 16'hA012);
      reset = 1'b0;
      push(16'h0000, 16'h1234); tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_op !== 6'b000100 || out_typ !== 2'b00 ||
          out_dst !== 4'h3 || out_src !== 16'h0024) begin
         errors++;
         $display("FAIL short_decode: got v=%b pc=%h op=%b typ=%b dst=%h src=%h want 1/0000/000100/00/3/0024",
                  out_valid, out_pc, out_op, out_typ, out_dst, out_src);
      end
      push(16'h0001, 16'h80F8); tick();
      checks++;
      if (out_op !== 6'b100000 || out_typ !== 2'b00 || out_dst !== 4'hF || out_src !== 16'hFFF8) begin
         errors++;
         $display("FAIL long_imm_decode: got op=%b typ=%b dst=%h src=%h want 100000/00/f/fff8", out_op, out_typ, out_dst, out_src);
      end
      reset = 1'b1; tick();
      load(16'h0001, 16'h81F8);
      reset = 1'b0;
      push(16'h0000, 16'h1234); tick();
      push(16'h0001, 16'h81F8); tick();
      checks++;
      if (out_op !== 6'b100000 || out_typ !== 2'b01 || out_dst !== 4'hF || out_src !== 16'h0008) begin
         errors++;
         $display("FAIL long_reg_decode: got op=%b typ=%b dst=%h src=%h want 100000/01/f/0008", out_op, out_typ, out_dst, out_src);
      end
      reset = 1'b1; tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL decode_drain: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_branch();
      do_reset();
      load(16'h0000, 16'h1234);
      load(16'h0001, 16'h80F8);
      load(16'h0002, 16'hA012);
      load(16'h0003, 16'h0333);
      reset = 1'b0;
      push(16'h0000, 16'h1234); tick();
      push(16'h0001, 16'h80F8); tick();
      push(16'h0002, 16'hA012); tick();
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_ir !== NOP || out_pc !== 16'h0002) begin
            errors++;
            $display("FAIL ctrl_wait_bubble: got v=%b ir=%h pc=%h want 0/e800/0002", out_valid, out_ir, out_pc);
         end
      end
      ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ctrl_done_cycle: got v=%b want 0", out_valid); end
      push(16'h0003, 16'h0333); tick();
      checks++; if (out_pc !== 16'h0003 || out_valid !== 1'b1) begin errors++; $display("FAIL branch_resume: got pc=%h v=%b want 0003/1", out_pc, out_valid); end
      reset = 1'b1; tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL branch_drain: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_redirect();
      do_reset();
      load(16'h0000, 16'h1234);
      load(16'h0001, 16'h80F8);
      load(16'h0002, 16'hA012);
      load(16'h0010, 16'h0510);
      reset = 1'b0;
      push(16'h0000, 16'h1234); tick();
      push(16'h0001, 16'h80F8); tick();
      push(16'h0002, 16'hA012); tick();
      tick();
      redir_valid = 1'b1; redir_pc = 16'h0010; stall = 1'b1;
      tick();
      redir_valid = 1'b0; stall = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_ir !== NOP) begin errors++; $display("FAIL redir_bubble: got v=%b ir=%h want 0/e800", out_valid, out_ir); end
      push(16'h0010, 16'h0510); tick();
      checks++; if (out_pc !== 16'h0010 || out_lastpc !== 16'h0002) begin errors++; $display("FAIL redir_target: got pc=%h lastpc=%h want 0010/0002", out_pc, out_lastpc); end
      reset = 1'b1; tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_drain: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_reverse();
      do_reset();
      load(16'h0000, 16'h0111);
      load(16'hFFFF, 16'h0222);
      reset = 1'b0; rev = 1'b1;
      push(16'h0000, 16'h0111); tick();
      rev = 1'b0;
      push(16'hFFFF, 16'h0222); tick();
      checks++; if (out_pc !== 16'hFFFF) begin errors++; $display("FAIL rev_wrap: got pc=%h want ffff", out_pc); end
      push(16'h0000, 16'h0111); tick();
      checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL fwd_wrap: got pc=%h want 0000", out_pc); end
      reset = 1'b1; tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rev_drain: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_imem_old_data();
      do_reset();
      load(16'h0000, 16'h0111);
      reset = 1'b0;
      im_we = 1'b1; im_waddr = 16'h0000; im_wdata = 16'h0999;
      push(16'h0000, 16'h0111); tick();
      im_we = 1'b0;
      checks++; if (out_ir !== 16'h0111) begin errors++; $display("FAIL imem_same_cycle: got ir=%h want 0111", out_ir); end
      reset = 1'b1; tick();
      reset = 1'b0;
      push(16'h0000, 16'h0999); tick();
      checks++; if (out_ir !== 16'h0999) begin errors++; $display("FAIL imem_written: got ir=%h want 0999", out_ir); end
      reset = 1'b1; tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL imem_drain: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_block_stall();
      logic [15:0] prog [8];
      prog = '{16'h1234, 16'h80F8, 16'h0002, 16'h0003, 16'h0004, 16'hE000, 16'h0666, 16'hC400};
      do_reset();
      for (int i = 0; i < 8; i++) load(16'(i), prog[i]);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin push(16'(i), prog[i]); tick(); end
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'h0003 || out_ir !== 16'h0003) begin
            errors++;
            $display("FAIL run_stall_hold: got v=%b pc=%h ir=%h want 1/0003/0003", out_valid, out_pc, out_ir);
         end
      end
      stall = 1'b0;
      push(16'h0004, prog[4]); tick();
      push(16'h0005, prog[5]); tick();
      for (int k = 0; k < 10; k++) begin
         stall      = (k >= 4 && k <= 6);
         release_op = (k == 5);
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_ir !== NOP || out_pc !== 16'h0005) begin
            errors++;
            $display("FAIL hold_bubble: got v=%b ir=%h pc=%h want 0/e800/0005 (cycle %0d)", out_valid, out_ir, out_pc, k);
         end
      end
      stall = 1'b0; release_op = 1'b1; ctrl_done = 1'b1;
      tick();
      release_op = 1'b0; ctrl_done = 1'b0;
      push(16'h0006, prog[6]); tick();
      checks++; if (out_pc !== 16'h0006) begin errors++; $display("FAIL hold_resume: got pc=%h want 0006", out_pc); end
      push(16'h0007, prog[7]); tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fail_hold: got v=%b want 0", out_valid); end
      reset = 1'b1; tick();
      checks++;
      if (out_pc !== 16'h0000 || out_valid !== 1'b0 || out_ir !== NOP) begin
         errors++;
         $display("FAIL reset_in_hold: got pc=%h v=%b ir=%h want 0000/0/e800", out_pc, out_valid, out_ir);
      end
      reset = 1'b0;
      push(16'h0000, prog[0]); tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin errors++; $display("FAIL run_after_reset: got v=%b pc=%h want 1/0000", out_valid, out_pc); end
      reset = 1'b1; tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL block_drain: got %0d pending want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_branch();
      test_redirect();
      test_reverse();
      test_imem_old_data();
      test_block_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
